// File: rtl/pc_run_ctrl.sv
// Run/stall sequencer for the program counter: turns the Start handshake and decode flags
// into one-hot PC commands, holds the PC across memory operations and counts retirements.
module pc_run_ctrl #(
  parameter int unsigned STALL_CYCLES = 4,
  parameter int unsigned CW           = 3
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          Start,
  input  logic          MemOp,
  input  logic          Halt,
  input  logic          Jen,
  input  logic          Zero,
  output logic          PcClr,
  output logic          PcInc,
  output logic          PcLoad,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] StallCnt,
  output logic [15:0]   InstrCount
);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StRun,
    StStall,
    StDone
  } state_e;

  localparam bit            UseStall = (STALL_CYCLES > 1);
  localparam logic [CW-1:0] LastCnt  = CW'(STALL_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   icnt_q, icnt_d;
  logic          done_q, done_d;
  logic          retire;
  logic          icnt_inc;
  logic          icnt_clr;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    PcClr    = 1'b0;
    PcInc    = 1'b0;
    PcLoad   = 1'b0;
    retire   = 1'b0;
    icnt_inc = 1'b0;
    icnt_clr = 1'b0;

    case (state_q)
      StIdle: begin
        if (Start) state_d = StArmed;
      end
      StArmed: begin
        PcClr = 1'b1;
        if (!Start) begin
          state_d  = StRun;
          icnt_clr = 1'b1;
        end
      end
      StRun: begin
        if (Start) begin
          state_d = StArmed;
        end else if (Halt) begin
          state_d  = StDone;
          icnt_inc = 1'b1;
        end else if (MemOp && UseStall) begin
          state_d = StStall;
          cnt_d   = CW'(1);
        end else begin
          retire = 1'b1;
        end
      end
      StStall: begin
        // Halt is deliberately not decoded here; the instruction is held stable.
        if (Start) begin
          state_d = StArmed;
          cnt_d   = '0;
        end else if (cnt_q < LastCnt) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          retire  = 1'b1;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StDone: begin
        if (Start) state_d = StArmed;
      end
      default: state_d = StIdle;
    endcase

    if (retire) begin
      PcLoad   = Jen & Zero;
      PcInc    = ~(Jen & Zero);
      icnt_inc = 1'b1;
    end

    // Saturating retirement counter.
    if (icnt_clr) begin
      icnt_d = '0;
    end else if (icnt_inc && (icnt_q != 16'hFFFF)) begin
      icnt_d = icnt_q + 16'd1;
    end else begin
      icnt_d = icnt_q;
    end

    if (state_d == StDone) begin
      done_d = 1'b1;
    end else if (state_d == StArmed) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      icnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      icnt_q  <= icnt_d;
      done_q  <= done_d;
    end
  end

  assign Busy       = (state_q == StRun) || (state_q == StStall);
  assign Done       = done_q;
  assign StallCnt   = cnt_q;
  assign InstrCount = icnt_q;

endmodule

// File: doc/pc_run_ctrl.md
# pc_run_ctrl

Run/stall sequencer for the program counter. It converts the host `Start` handshake, decoded memory-operation and halt flags, and branch conditions into one-hot PC commands (clear, increment, load jump target). It holds the PC for a fixed number of cycles on each load/store and reports run status and a retired-instruction count. It sits between the decoder/ALU flags and the PC register, and replaces the ad-hoc stall counting inside the PC.

## Interface
Parameters:
- `STALL_CYCLES`, default 4: total cycles a memory instruction occupies, including its RUN cycle; legal range 1..2^CW-1.
- `CW`, default 3: width of the stall counter.

Ports:
- `Clk`  input  1  single clock; all state updates on its rising edge.
- `ResetN`  input  1  synchronous, active-low reset.
- `Start`  input  1  host level. High = hold/arm; a high-to-low transition launches the program from PC 0.
- `MemOp`  input  1  current instruction is a load/store.
- `Halt`  input  1  current instruction is halt.
- `Jen`  input  1  current instruction is a conditional jump.
- `Zero`  input  1  ALU zero flag.
- `PcClr`  output  1  PC loads 0 this edge.
- `PcInc`  output  1  PC loads PC+1 this edge.
- `PcLoad`  output  1  PC loads the jump target this edge.
- `Busy`  output  1  program executing (RUN or STALL).
- `Done`  output  1  program halted; sticky until the next arm.
- `StallCnt`  output  CW  cycles spent so far in the current stall.
- `InstrCount`  output  16  instructions retired since launch.

## Operation
- States: IDLE, ARMED, RUN, STALL, DONE. Encoding is free. State is registered.
- `ResetN`=0 at an edge: state goes to IDLE; `StallCnt`=0, `InstrCount`=0, `Done`=0. `ResetN` overrides everything, including mid-stall.
- IDLE: all commands are 0. `Start`=1 -> ARMED.
- ARMED: `PcClr`=1 every cycle. `Done` clears on entry. `Start`=0 -> RUN, and `InstrCount` is cleared to 0 on that edge.
- RUN, evaluated in priority order:
  - `Start`=1 -> ARMED (abort). No PC command is issued.
  - `Halt`=1 -> DONE. No PC command is issued. `InstrCount`+1.
  - `MemOp`=1 and `STALL_CYCLES`>1 -> STALL. `StallCnt`<=1. No PC command is issued.
  - Otherwise retire the instruction: `PcLoad`=1 if `Jen`&`Zero`, else `PcInc`=1. `InstrCount`+1. Stay in RUN.
- STALL:
  - `Start`=1 -> ARMED. `StallCnt`<=0.
  - `StallCnt`<`STALL_CYCLES`-1: `StallCnt`+1. No PC command is issued.
  - `StallCnt`==`STALL_CYCLES`-1: retire the instruction (`PcLoad` or `PcInc` as in RUN, using `Jen`/`Zero` sampled this cycle). `InstrCount`+1. `StallCnt`<=0. -> RUN.
  - `Halt` is ignored in STALL; the datapath holds the instruction stable.
- DONE: `Done`=1. `Start`=1 -> ARMED.
- `PcClr`, `PcInc` and `PcLoad` are combinational from state and inputs, and at most one is high in any cycle. `Busy` is decoded from the registered state. `Done` is registered.
- `InstrCount` saturates at 0xFFFF and does not wrap.
- With `STALL_CYCLES`=1, `MemOp` is treated as an ordinary instruction.

## Timing
- Reset values of all outputs: `PcClr`=`PcInc`=`PcLoad`=0, `Busy`=0, `Done`=0, `StallCnt`=0, `InstrCount`=0.
- `Start` falls before edge k: RUN from cycle k. The first PC command is asserted in cycle k and takes effect at edge k+1.
- A non-memory instruction occupies 1 cycle. A memory instruction occupies exactly `STALL_CYCLES` cycles: 1 RUN cycle plus `STALL_CYCLES`-1 STALL cycles. The PC updates only on the edge ending the last cycle.
- Halt: `Done` rises and `Busy` falls one cycle after the halt cycle. The PC holds the address of the halt instruction.
- `Start` asserted in any state other than IDLE/ARMED: ARMED on the next cycle, and `PcClr` one cycle after `Start` is seen.

## Test plan
- Reset, then `Start` held high 3 cycles then low, then 5 plain instructions: `PcClr` high 3 cycles; `PcInc` high 5 consecutive cycles; `InstrCount`=5; `Busy`=1 throughout.
- `MemOp`=1 with `STALL_CYCLES`=4: `StallCnt` reads 1, 2, 3; `PcInc` is high only on the 4th cycle; `InstrCount` rises by 1; back to RUN.
- `Jen`=1, `Zero`=1 at the end of a stall, then `Jen`=1, `Zero`=0 in RUN: `PcLoad`=1 on the stall's final cycle, then `PcInc`=1; `PcLoad` and `PcInc` are never high together.
- `Halt` after 7 instructions: DONE; `Done`=1, `Busy`=0, `InstrCount`=8, no PC commands. `Start`=1 then clears `Done` and asserts `PcClr`.
- `Start`=1 at `StallCnt`=2: ARMED next cycle; `StallCnt`=0; no `PcInc` issued. `ResetN`=0 mid-stall: IDLE with all outputs 0.
- 65540 retired instructions: `InstrCount` holds at 0xFFFF.
